bht_update_queue: RTL and testbench

BHT_UPDATE_QUEUE -- requirements
Module: bht_update_queue

---
 rtl/bht_update_queue_pkg.sv | 20 ++
 rtl/bht_update_queue_if.sv | 32 +++
 rtl/bht_update_queue_ring.sv | 60 ++++++
 rtl/bht_update_queue.sv | 98 +++++++++
 tb/tb_bht_update_queue.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/bht_update_queue_pkg.sv
// Shared core types for the branch-history update path.
// No logic: type and width definitions only.
// No flow control.
package bht_update_queue_pkg;

    // Widest branch PC carried by the shared update record.
    localparam int unsigned CORE_VLEN = 64;

    typedef enum logic {
        JUMP        = 1'b0,
        CONDITIONAL = 1'b1
    } branch_type_t;

    typedef struct packed {
        logic                 valid;
        logic [CORE_VLEN-1:0] pc;
        logic                 taken;
    } bht_update_t;

endpackage

// File: rtl/bht_update_queue_if.sv
// Resolved-branch input bus and BHT update output bus of the update queue.
// Wiring only; no latency.
// The BHT update side uses valid/ready; the resolved side has no backpressure.
interface bht_update_queue_if
    import bht_update_queue_pkg::*;
#(
    parameter int unsigned VLEN = 64
);
    logic             resolved_valid_i;
    logic [VLEN-1:0]  resolved_pc_i;
    logic             resolved_taken_i;
    branch_type_t     resolved_type_i;

    logic             bht_update_valid_o;
    logic [VLEN-1:0]  bht_update_pc_o;
    logic             bht_update_taken_o;
    logic             bht_ready_i;

    // Execute stage and BHT side of the bus.
    modport master (
        output resolved_valid_i, resolved_pc_i, resolved_taken_i, resolved_type_i,
        output bht_ready_i,
        input  bht_update_valid_o, bht_update_pc_o, bht_update_taken_o
    );

    // The queue itself.
    modport slave (
        input  resolved_valid_i, resolved_pc_i, resolved_taken_i, resolved_type_i,
        input  bht_ready_i,
        output bht_update_valid_o, bht_update_pc_o, bht_update_taken_o
    );
endinterface

// File: rtl/bht_update_queue_ring.sv
// Ring storage of {pc, taken} with power-of-two wrapping read/write pointers.
// Write visible at the read port one cycle after push; read is combinational.
// No fullness tracking: the caller only pushes when a slot is free.
module bht_update_ring #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned VLEN  = 64
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [VLEN-1:0] wr_pc_i,
    input  logic            wr_taken_i,
    output logic [VLEN-1:0] rd_pc_o,
    output logic            rd_taken_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [VLEN-1:0]  pc_mem_q [DEPTH];
    logic [DEPTH-1:0] taken_mem_q;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;

    // Pointer advance; clear returns both to slot 0. DEPTH is a power of two, so overflow wraps.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage; contents are only observed through occupied slots, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_i && !clr_i) begin
            pc_mem_q[wr_ptr_q]    <= wr_pc_i;
            taken_mem_q[wr_ptr_q] <= wr_taken_i;
        end
    end

    assign rd_pc_o    = pc_mem_q[rd_ptr_q];
    assign rd_taken_o = taken_mem_q[rd_ptr_q];

endmodule

// File: rtl/bht_update_queue.sv
// Buffers resolved conditional-branch outcomes and feeds them to the BHT update port in order.
// One cycle from enqueue to head visibility; no bypass from resolved inputs to outputs.
// BHT ready stalls the head; on a full queue without a pop the new update is dropped and counted.
module bht_update_queue
    import bht_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned VLEN  = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_bp_i,
    bht_update_queue_if.slave        bq,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     drop_o,
    output logic [7:0]               drop_cnt_o
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]   count_q, count_d;
    logic            drop_q, drop_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;

    logic            push_req, full, head_vld, pop, push;
    logic [VLEN-1:0] rd_pc;
    logic            rd_taken;
    bht_update_t     head;

    // JUMPs never touch the BHT, so they are neither queued nor counted as drops.
    assign push_req = bq.resolved_valid_i && (bq.resolved_type_i == CONDITIONAL);
    assign head_vld = (count_q != '0);
    assign full     = (count_q == CW'(DEPTH));
    // Flush discards both sides of the cycle; a pop frees the slot a same-cycle push needs.
    assign pop      = head_vld && bq.bht_ready_i && !flush_bp_i;
    assign push     = push_req && (!full || pop) && !flush_bp_i;

    bht_update_ring #(
        .DEPTH (DEPTH),
        .VLEN  (VLEN)
    ) u_ring (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (flush_bp_i),
        .push_i     (push),
        .pop_i      (pop),
        .wr_pc_i    (bq.resolved_pc_i),
        .wr_taken_i (bq.resolved_taken_i),
        .rd_pc_o    (rd_pc),
        .rd_taken_o (rd_taken)
    );

    // Occupancy, drop pulse and saturating drop counter next state.
    always_comb begin
        count_d    = count_q;
        drop_d     = 1'b0;
        drop_cnt_d = drop_cnt_q;
        if (flush_bp_i) begin
            count_d = '0;
        end else begin
            if (push && !pop)      count_d = count_q + CW'(1);
            else if (pop && !push) count_d = count_q - CW'(1);
            drop_d = push_req && full && !pop;
            if (drop_d && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    // Counter and drop-status registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q    <= '0;
            drop_q     <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            count_q    <= count_d;
            drop_q     <= drop_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Head record; payload forced to zero when empty so stale slots never leak out.
    always_comb begin
        head       = '0;
        head.valid = head_vld;
        if (head_vld) begin
            head.pc[VLEN-1:0] = rd_pc;
            head.taken        = rd_taken;
        end
    end

    assign bq.bht_update_valid_o = head.valid;
    assign bq.bht_update_pc_o    = head.pc[VLEN-1:0];
    assign bq.bht_update_taken_o = head.taken;

    assign count_o    = count_q;
    assign drop_o     = drop_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_bht_update_queue.sv
// Directed bench for bht_update_queue at DEPTH=4, VLEN=64.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Every expected value below is hand-computed from the queue's intended behaviour.
module tb_bht_update_queue;
    import bht_update_queue_pkg::*;

    logic       clk_i;
    logic       rst_ni;
    logic       flush_bp_i;
    logic [2:0] count_o;
    logic       drop_o;
    logic [7:0] drop_cnt_o;

    int total;
    int passed;

    bht_update_queue_if #(.VLEN(64)) bq ();

    bht_update_queue #(
        .DEPTH (4),
        .VLEN  (64)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .flush_bp_i (flush_bp_i),
        .bq         (bq),
        .count_o    (count_o),
        .drop_o     (drop_o),
        .drop_cnt_o (drop_cnt_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drv(input logic v, input logic [63:0] pc, input logic tk, input branch_type_t ty);
        bq.resolved_valid_i = v;
        bq.resolved_pc_i    = pc;
        bq.resolved_taken_i = tk;
        bq.resolved_type_i  = ty;
    endtask

    initial begin
        total  = 0;
        passed = 0;
        rst_ni     = 1'b0;
        flush_bp_i = 1'b0;
        bq.bht_ready_i = 1'b0;
        drv(1'b0, 64'h0, 1'b0, JUMP);

        // Reset state
        #1;
        chk("rst_count", 64'(count_o), 64'd0);
        chk("rst_valid", 64'(bq.bht_update_valid_o), 64'd0);
        chk("rst_pc", bq.bht_update_pc_o, 64'h0);
        chk("rst_drop", 64'(drop_o), 64'd0);
        chk("rst_dropcnt", 64'(drop_cnt_o), 64'd0);
        tick();
        tick();
        rst_ni = 1'b1;

        // Single push with ready high: visible next cycle, popped the cycle after
        bq.bht_ready_i = 1'b1;
        drv(1'b1, 64'h1000, 1'b1, CONDITIONAL);
        tick();
        drv(1'b0, 64'h0, 1'b0, JUMP);
        chk("single_valid", 64'(bq.bht_update_valid_o), 64'd1);
        chk("single_pc", bq.bht_update_pc_o, 64'h1000);
        chk("single_taken", 64'(bq.bht_update_taken_o), 64'd1);
        chk("single_count", 64'(count_o), 64'd1);
        tick();
        chk("single_popped_count", 64'(count_o), 64'd0);
        chk("single_popped_valid", 64'(bq.bht_update_valid_o), 64'd0);

        // JUMP is ignored
        drv(1'b1, 64'h2000, 1'b1, JUMP);
        tick();
        drv(1'b0, 64'h0, 1'b0, JUMP);
        chk("jump_count", 64'(count_o), 64'd0);
        chk("jump_drop", 64'(drop_o), 64'd0);
        chk("jump_valid", 64'(bq.bht_update_valid_o), 64'd0);

        // Overflow: five pushes with ready low
        bq.bht_ready_i = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            drv(1'b1, 64'(i) * 64'h100, 1'(i), CONDITIONAL);
            tick();
        end
        chk("fill_count", 64'(count_o), 64'd4);
        chk("fill_nodrop", 64'(drop_o), 64'd0);
        drv(1'b1, 64'h500, 1'b1, CONDITIONAL);
        tick();
        drv(1'b0, 64'h0, 1'b0, JUMP);
        chk("ovf_count", 64'(count_o), 64'd4);
        chk("ovf_drop", 64'(drop_o), 64'd1);
        chk("ovf_dropcnt", 64'(drop_cnt_o), 64'd1);
        tick();
        chk("ovf_drop_pulse_end", 64'(drop_o), 64'd0);
        chk("stall_hold_pc", bq.bht_update_pc_o, 64'h100);
        bq.bht_ready_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain_pc%0d", i), bq.bht_update_pc_o, 64'(i) * 64'h100);
            chk($sformatf("drain_tk%0d", i), 64'(bq.bht_update_taken_o), 64'(i % 2));
            tick();
        end
        chk("drain_count", 64'(count_o), 64'd0);

        // Simultaneous push and pop while full
        bq.bht_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 64'hA00 + 64'(i) * 64'h10, 1'b0, CONDITIONAL);
            tick();
        end
        chk("pp_full_count", 64'(count_o), 64'd4);
        drv(1'b1, 64'hB00, 1'b1, CONDITIONAL);
        bq.bht_ready_i = 1'b1;
        tick();
        drv(1'b0, 64'h0, 1'b0, JUMP);
        chk("pp_count", 64'(count_o), 64'd4);
        chk("pp_nodrop", 64'(drop_o), 64'd0);
        chk("pp_dropcnt", 64'(drop_cnt_o), 64'd1);
        chk("pp_head1", bq.bht_update_pc_o, 64'hA10);
        tick();
        chk("pp_head2", bq.bht_update_pc_o, 64'hA20);
        tick();
        chk("pp_head3", bq.bht_update_pc_o, 64'hA30);
        tick();
        chk("pp_head4", bq.bht_update_pc_o, 64'hB00);
        chk("pp_head4_tk", 64'(bq.bht_update_taken_o), 64'd1);
        tick();
        chk("pp_empty", 64'(count_o), 64'd0);

        // Flush at count=3 with a simultaneous push
        bq.bht_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 64'hC00 + 64'(i) * 64'h10, 1'b1, CONDITIONAL);
            tick();
        end
        chk("fl_pre_count", 64'(count_o), 64'd3);
        flush_bp_i = 1'b1;
        drv(1'b1, 64'hC30, 1'b1, CONDITIONAL);
        tick();
        flush_bp_i = 1'b0;
        chk("fl_count", 64'(count_o), 64'd0);
        chk("fl_valid", 64'(bq.bht_update_valid_o), 64'd0);
        chk("fl_pc", bq.bht_update_pc_o, 64'h0);
        chk("fl_drop", 64'(drop_o), 64'd0);
        chk("fl_dropcnt", 64'(drop_cnt_o), 64'd1);
        drv(1'b1, 64'hD00, 1'b0, CONDITIONAL);
        tick();
        drv(1'b0, 64'h0, 1'b0, JUMP);
        chk("post_fl_count", 64'(count_o), 64'd1);
        chk("post_fl_pc", bq.bht_update_pc_o, 64'hD00);
        bq.bht_ready_i = 1'b1;
        tick();
        chk("post_fl_empty", 64'(count_o), 64'd0);

        // Saturation: fill, then 300 overflowing pushes (1 + 300 drops clips at 255)
        bq.bht_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 64'h5000 + 64'(i), 1'b1, CONDITIONAL);
            tick();
        end
        for (int i = 0; i < 300; i++) begin
            drv(1'b1, 64'h6000 + 64'(i), 1'b0, CONDITIONAL);
            tick();
        end
        chk("sat_dropcnt", 64'(drop_cnt_o), 64'd255);
        chk("sat_drop", 64'(drop_o), 64'd1);
        chk("sat_count", 64'(count_o), 64'd4);
        chk("sat_head", bq.bht_update_pc_o, 64'h5000);

        // Asynchronous reset mid-stream
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_count", 64'(count_o), 64'd0);
        chk("arst_valid", 64'(bq.bht_update_valid_o), 64'd0);
        chk("arst_pc", bq.bht_update_pc_o, 64'h0);
        chk("arst_taken", 64'(bq.bht_update_taken_o), 64'd0);
        chk("arst_drop", 64'(drop_o), 64'd0);
        chk("arst_dropcnt", 64'(drop_cnt_o), 64'd0);
        drv(1'b1, 64'hE00, 1'b1, CONDITIONAL);
        rst_ni = 1'b1;
        tick();
        drv(1'b0, 64'h0, 1'b0, JUMP);
        chk("post_rst_count", 64'(count_o), 64'd1);
        chk("post_rst_pc", bq.bht_update_pc_o, 64'hE00);
        chk("post_rst_dropcnt", 64'(drop_cnt_o), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
